// File: rtl/ecp5pll_pkg.sv
// Shared types and constants for the ECP5 PLL dynamic phase-shift controller.
package ecp5pll_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CALC   = 3'd1,
    SETUP  = 3'd2,
    PULSE  = 3'd3,
    SETTLE = 3'd4,
    DONE   = 3'd5
  } phase_state_t;

  localparam logic PHASEDIR_DELAY   = 1'b0;
  localparam logic PHASEDIR_ADVANCE = 1'b1;

  localparam logic [1:0] CLKOP  = 2'd0;
  localparam logic [1:0] CLKOS  = 2'd1;
  localparam logic [1:0] CLKOS2 = 2'd2;
  localparam logic [1:0] CLKOS3 = 2'd3;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ecp5pll_lock_filter.sv
// PLL lock qualification: 2-flop synchroniser followed by a saturating debounce counter.
module ecp5pll_lock_filter #(
  parameter int LOCK_CYCLES = 1024
) (
  input  logic clk_i,
  input  logic reset,
  input  logic locked_i,
  output logic locked_o,
  output logic lock_lost
);

  localparam int CNT_W = $clog2(LOCK_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

  logic [1:0]       sync_r;
  logic [CNT_W-1:0] cnt_r;
  logic             locked_r;
  logic             lost_r;

  // Synchronise raw lock and count consecutive high samples
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      sync_r   <= 2'b00;
      cnt_r    <= '0;
      locked_r <= 1'b0;
      lost_r   <= 1'b0;
    end else begin
      sync_r <= {sync_r[0], locked_i};
      if (!sync_r[1]) begin
        cnt_r    <= '0;
        locked_r <= 1'b0;
        lost_r   <= locked_r;
      end else begin
        lost_r <= 1'b0;
        if (cnt_r >= CNT_LAST) begin
          locked_r <= 1'b1;
        end else begin
          cnt_r <= cnt_r + CNT_W'(1'b1);
        end
      end
    end
  end

  assign locked_o  = locked_r;
  assign lock_lost = lost_r;

endmodule

// File: rtl/ecp5pll_phase_ctrl.sv
// Moves up to four ECP5 PLL outputs to an absolute phase via shortest-path
// phasestep pulses, tracking each channel's position and aborting on lock loss.
module ecp5pll_phase_ctrl
  import ecp5pll_pkg::*;
#(
  parameter int CHANNELS      = 4,
  parameter int STEPS         = 64,
  parameter int SETUP_CYCLES  = 2,
  parameter int PULSE_CYCLES  = 4,
  parameter int SETTLE_CYCLES = 8,
  parameter int LOCK_CYCLES   = 1024,
  localparam int POS_W        = $clog2(STEPS)
) (
  input  logic                      clk_i,
  input  logic                      reset,
  input  logic                      locked_i,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [1:0]                req_chan,
  input  logic [POS_W-1:0]          req_pos,
  output logic                      done,
  output logic                      err,
  output logic                      busy,
  output logic                      locked_o,
  output logic                      lock_lost,
  output logic [CHANNELS*POS_W-1:0] pos_o,
  output logic [1:0]                phasesel,
  output logic                      phasedir,
  output logic                      phasestep,
  output logic                      phaseloadreg
);

  localparam int CYC_W = $clog2(max3(SETUP_CYCLES, PULSE_CYCLES, SETTLE_CYCLES) + 1);
  localparam logic [POS_W:0]   STEPS_L  = (POS_W + 1)'(STEPS);
  localparam logic [POS_W:0]   HALF_L   = (POS_W + 1)'(STEPS / 2);
  localparam logic [POS_W-1:0] LAST_POS = POS_W'(STEPS - 1);
  localparam logic [CYC_W-1:0] SETUP_L  = CYC_W'(SETUP_CYCLES - 1);
  localparam logic [CYC_W-1:0] PULSE_L  = CYC_W'(PULSE_CYCLES - 1);
  localparam logic [CYC_W-1:0] SETTLE_L = CYC_W'(SETTLE_CYCLES - 1);

  phase_state_t     state_r, state_s;
  logic [1:0]       chan_r;
  logic [POS_W-1:0] tgt_r;
  logic [POS_W:0]   steps_r;
  logic [CYC_W-1:0] cyc_r, cyc_load_s;
  logic [POS_W-1:0] pos_r [CHANNELS];
  logic [POS_W-1:0] cur_s;
  logic [POS_W:0]   d_s, n_s, steps_left_s;
  logic             bad_s, adv_s, cyc_last_s, settle_first_s;
  logic             lock_s, lock_lost_s;
  logic             done_r, err_r, busy_r, step_r, dir_r;
  logic [1:0]       sel_r;

  ecp5pll_lock_filter #(
    .LOCK_CYCLES (LOCK_CYCLES)
  ) u_lock_filter (
    .clk_i     (clk_i),
    .reset     (reset),
    .locked_i  (locked_i),
    .locked_o  (lock_s),
    .lock_lost (lock_lost_s)
  );

  // Current position of the latched channel
  always_comb begin
    cur_s = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      cur_s = (chan_r == 2'(i)) ? pos_r[i] : cur_s;
    end
  end

  // Request validation, modular distance and shortest direction (ties delay)
  always_comb begin
    bad_s = ({1'b0, chan_r} >= 3'(CHANNELS)) || ({1'b0, tgt_r} >= STEPS_L);
    if ({1'b0, tgt_r} >= {1'b0, cur_s}) begin
      d_s = {1'b0, tgt_r} - {1'b0, cur_s};
    end else begin
      d_s = {1'b0, tgt_r} + STEPS_L - {1'b0, cur_s};
    end
    adv_s          = (d_s > HALF_L);
    n_s            = adv_s ? (STEPS_L - d_s) : d_s;
    cyc_last_s     = (cyc_r == '0);
    settle_first_s = (state_r == SETTLE) && (cyc_r == SETTLE_L);
    steps_left_s   = settle_first_s ? (steps_r - (POS_W + 1)'(1'b1)) : steps_r;
  end

  // Next-state logic; a lock fall overrides everything
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_valid && req_ready) state_s = CALC;
        else                        state_s = IDLE;
      end
      CALC: begin
        if (bad_s || (d_s == '0)) state_s = DONE;
        else                      state_s = SETUP;
      end
      SETUP: begin
        if (cyc_last_s) state_s = PULSE;
        else            state_s = SETUP;
      end
      PULSE: begin
        if (cyc_last_s) state_s = SETTLE;
        else            state_s = PULSE;
      end
      SETTLE: begin
        if (!cyc_last_s)              state_s = SETTLE;
        else if (steps_left_s != '0)  state_s = PULSE;
        else                          state_s = DONE;
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
    if (lock_lost_s) state_s = IDLE;
    else             state_s = state_s;
  end

  // Cycle-counter reload value for the state being entered
  always_comb begin
    case (state_s)
      SETUP:   cyc_load_s = SETUP_L;
      PULSE:   cyc_load_s = PULSE_L;
      SETTLE:  cyc_load_s = SETTLE_L;
      default: cyc_load_s = '0;
    endcase
  end

  // State, counters, per-channel positions and registered outputs
  always_ff @(posedge clk_i or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      chan_r  <= 2'd0;
      tgt_r   <= '0;
      steps_r <= '0;
      cyc_r   <= '0;
      done_r  <= 1'b0;
      err_r   <= 1'b0;
      busy_r  <= 1'b0;
      step_r  <= 1'b0;
      dir_r   <= PHASEDIR_DELAY;
      sel_r   <= CLKOP;
      for (int i = 0; i < CHANNELS; i++) pos_r[i] <= '0;
    end else begin
      state_r <= state_s;
      if (state_s != state_r) cyc_r <= cyc_load_s;
      else if (!cyc_last_s)   cyc_r <= cyc_r - CYC_W'(1'b1);
      if ((state_r == IDLE) && (state_s == CALC)) begin
        chan_r <= req_chan;
        tgt_r  <= req_pos;
      end
      if ((state_r == CALC) && !bad_s) begin
        sel_r   <= chan_r;
        dir_r   <= adv_s ? PHASEDIR_ADVANCE : PHASEDIR_DELAY;
        steps_r <= n_s;
      end
      if (settle_first_s) steps_r <= steps_left_s;
      for (int i = 0; i < CHANNELS; i++) begin
        if (lock_lost_s) begin
          pos_r[i] <= '0;
        end else if (settle_first_s && (chan_r == 2'(i))) begin
          if (dir_r == PHASEDIR_ADVANCE) pos_r[i] <= (pos_r[i] == '0) ? LAST_POS : pos_r[i] - POS_W'(1'b1);
          else                           pos_r[i] <= (pos_r[i] == LAST_POS) ? '0 : pos_r[i] + POS_W'(1'b1);
        end
      end
      step_r <= (state_s == PULSE);
      busy_r <= (state_s != IDLE);
      done_r <= (state_s == DONE);
      err_r  <= (state_r == CALC) && (state_s == DONE) && bad_s;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_pos
    assign pos_o[g*POS_W +: POS_W] = pos_r[g];
  end

  assign req_ready    = (state_r == IDLE) && lock_s;
  assign done         = done_r;
  assign err          = err_r;
  assign busy         = busy_r;
  assign locked_o     = lock_s;
  assign lock_lost    = lock_lost_s;
  assign phasesel     = sel_r;
  assign phasedir     = dir_r;
  assign phasestep    = step_r;
  assign phaseloadreg = 1'b0;

endmodule

// File: tb/tb_ecp5pll_phase_ctrl.sv
// Directed bench for ecp5pll_phase_ctrl: vector table of phase requests plus lock and reset sequences.
module tb_ecp5pll_phase_ctrl;

  localparam int CH = 3;
  localparam int PW = 6;

  logic          clk = 1'b0;
  logic          reset, locked_i, req_valid;
  logic [1:0]    req_chan;
  logic [PW-1:0] req_pos;
  logic          req_ready, done, err, busy, locked_o, lock_lost;
  logic [CH*PW-1:0] pos_o;
  logic [1:0]    phasesel;
  logic          phasedir, phasestep, phaseloadreg;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [1:0]    chan;
    logic [PW-1:0] pos;
    logic          exp_err;
    int            exp_n;
    logic          exp_dir;
    int            exp_done;
  } vec_t;

  vec_t vecs[9];
  logic [PW-1:0] model [CH];

  always #5 clk = ~clk;

  ecp5pll_phase_ctrl #(
    .CHANNELS(CH), .STEPS(64), .SETUP_CYCLES(2), .PULSE_CYCLES(4),
    .SETTLE_CYCLES(8), .LOCK_CYCLES(16)
  ) dut (
    .clk_i(clk), .reset(reset), .locked_i(locked_i), .req_valid(req_valid),
    .req_ready(req_ready), .req_chan(req_chan), .req_pos(req_pos), .done(done),
    .err(err), .busy(busy), .locked_o(locked_o), .lock_lost(lock_lost),
    .pos_o(pos_o), .phasesel(phasesel), .phasedir(phasedir),
    .phasestep(phasestep), .phaseloadreg(phaseloadreg)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [CH*PW-1:0] pack();
    return {model[2], model[1], model[0]};
  endfunction

  task automatic run_vec(input vec_t v);
    int done_cyc = -1, rises = 0, high = 0, first_rise = -1, last_fall = -100;
    int pos_chg = 0, good_chg = 0;
    logic errseen = 1'b0, prev_step = 1'b0, dir_ok = 1'b1, sel_ok = 1'b1;
    logic [CH*PW-1:0] prev_pos;
    req_chan  = v.chan;
    req_pos   = v.pos;
    req_valid = 1'b1;
    prev_pos  = pos_o;
    check("ready_before", req_ready, 1);
    for (int c = 0; c < 500 && done_cyc < 0; c++) begin
      if (phasestep && !prev_step) begin
        rises++;
        if (first_rise < 0) first_rise = c;
      end
      if (!phasestep && prev_step) last_fall = c;
      if (phasestep) begin
        high++;
        if (phasedir !== v.exp_dir) dir_ok = 1'b0;
        if (phasesel !== v.chan) sel_ok = 1'b0;
      end
      if (pos_o !== prev_pos) begin
        pos_chg++;
        if (c == last_fall + 1) good_chg++;
      end
      if (done) begin
        done_cyc = c;
        errseen  = err;
      end
      prev_step = phasestep;
      prev_pos  = pos_o;
      @(posedge clk); #1;
      if (c == 0) req_valid = 1'b0;
    end
    check("done_cycle", done_cyc, v.exp_done);
    check("err", errseen, v.exp_err);
    check("pulse_count", rises, v.exp_n);
    check("pulse_high_cycles", high, v.exp_n * 4);
    if (v.exp_n > 0) begin
      check("first_pulse_cycle", first_rise, 4);
      check("phasedir", dir_ok, 1);
      check("phasesel", sel_ok, 1);
    end
    check("pos_change_count", pos_chg, v.exp_n);
    check("pos_change_timing", good_chg, v.exp_n);
    if (!v.exp_err && v.chan < 2'(CH)) model[v.chan] = v.pos;
    check("pos_o", pos_o, pack());
    check("ready_after", req_ready, 1);
    check("busy_after", busy, 0);
  endtask

  initial begin
    int ll_cnt, ll_cyc, done_seen, wait_c;
    vecs[0] = '{2'd1, 6'd5,  1'b0, 5,  1'b0, 64};
    vecs[1] = '{2'd2, 6'd60, 1'b0, 4,  1'b1, 52};
    vecs[2] = '{2'd0, 6'd32, 1'b0, 32, 1'b0, 388};
    vecs[3] = '{2'd3, 6'd7,  1'b1, 0,  1'b0, 2};
    vecs[4] = '{2'd1, 6'd5,  1'b0, 0,  1'b0, 2};
    vecs[5] = '{2'd1, 6'd0,  1'b0, 5,  1'b1, 64};
    vecs[6] = '{2'd2, 6'd28, 1'b0, 32, 1'b0, 388};
    vecs[7] = '{2'd0, 6'd31, 1'b0, 1,  1'b1, 16};
    vecs[8] = '{2'd1, 6'd3,  1'b0, 3,  1'b0, 40};
    for (int i = 0; i < CH; i++) model[i] = '0;

    reset = 1'b1; locked_i = 1'b0; req_valid = 1'b0; req_chan = 2'd0; req_pos = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_outputs", {done, err, busy, locked_o, lock_lost, phasestep, phasedir, phaseloadreg, req_ready}, 0);
    check("rst_pos", pos_o, 0);
    check("rst_sel", phasesel, 0);

    @(posedge clk); #1;
    reset = 1'b0;
    locked_i = 1'b1;
    repeat (17) @(posedge clk);
    #1;
    check("lock_before_18", locked_o, 0);
    check("ready_unlocked", req_ready, 0);
    @(posedge clk); #1;
    check("lock_at_18", locked_o, 1);
    check("ready_locked", req_ready, 1);

    for (int i = 0; i < 8; i++) run_vec(vecs[i]);

    // 10-step delay on channel 0 (31 -> 41), lock dropped just before pulse 3
    req_chan = 2'd0; req_pos = 6'd41; req_valid = 1'b1;
    ll_cnt = 0; ll_cyc = -1; done_seen = 0;
    for (int c = 0; c < 150; c++) begin
      if (lock_lost) begin
        ll_cnt++;
        ll_cyc = c;
      end
      if (done) done_seen++;
      if (c == 39) begin
        model[0] = 6'd34;
        check("pos_before_drop", pos_o, pack());
        locked_i = 1'b0;
      end
      if (c == 42) begin
        check("pulse3_active", phasestep, 1);
        check("locked_fell", locked_o, 0);
        check("loadreg_tied", phaseloadreg, 0);
      end
      if (c == 43) check("abort_step_low", phasestep, 0);
      @(posedge clk); #1;
      if (c == 0) req_valid = 1'b0;
    end
    for (int i = 0; i < CH; i++) model[i] = '0;
    check("lock_lost_pulses", ll_cnt, 1);
    check("lock_lost_cycle", ll_cyc, 42);
    check("no_done_on_abort", done_seen, 0);
    check("pos_cleared", pos_o, pack());
    check("ready_while_unlocked", req_ready, 0);
    check("idle_after_abort", busy, 0);

    locked_i = 1'b1;
    repeat (17) @(posedge clk);
    #1;
    check("relock_before", req_ready, 0);
    @(posedge clk); #1;
    check("relock_ready", req_ready, 1);

    run_vec(vecs[8]);

    // Asynchronous reset while phasestep is high
    req_chan = 2'd2; req_pos = 6'd5; req_valid = 1'b1;
    wait_c = 0;
    while (!phasestep && wait_c < 50) begin
      @(posedge clk); #1;
      req_valid = 1'b0;
      wait_c++;
    end
    check("reached_pulse", phasestep, 1);
    #2;
    reset = 1'b1;
    #1;
    check("async_rst_step", phasestep, 0);
    check("async_rst_busy", busy, 0);
    check("async_rst_locked", locked_o, 0);
    check("async_rst_pos", pos_o, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
